// File: rtl/pair_diff_pkg.sv
// Shared types and helpers for the pair difference channel.
// Contents: FSM state enum, default offset, saturating clip helper.
// The helper works on a fixed wide signed value, so any result width below MAX_W can use it.
package pair_diff_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    WAIT_B = 1'b1
  } state_t;

  localparam int unsigned DEF_OFFSET = 32'h0000_07F0;

  // Widest result the clip helper supports, and its internal signed width.
  localparam int MAX_W = 64;
  localparam int SW    = MAX_W + 2;

  // Clip a two's-complement value s to [0, 2^w-1].
  // Returns {clipped value, overflow}. Overflow sits in the LSB, so a caller
  // can truncate the result to (w+1) bits and get {value[w-1:0], ovf}.
  function automatic logic [MAX_W:0] sat_clip(input logic [SW-1:0] s, input int unsigned w);
    logic [SW-1:0]    lim;
    logic             neg;
    logic             big;
    logic [MAX_W-1:0] clip;
    lim = (SW'(1) << w) - SW'(1);
    neg = s[SW-1];
    big = !neg && (s > lim);
    if (neg)      clip = '0;
    else if (big) clip = lim[MAX_W-1:0];
    else          clip = s[MAX_W-1:0];
    return {clip, neg | big};
  endfunction

endpackage

// File: rtl/pair_diff_arith.sv
// Two-stage subtract / offset / saturate pipeline for one A,B pair.
// Latency: launch at cycle N -> o_dval, out_data, o_ovf registered for cycle N+2.
// Backpressure: none; accepts a launch every cycle, results never cancelled.
// Ports: clk, rst (async active-low), vld/a/b/order launch, out_data/o_dval/o_ovf result.
module pair_diff_arith
  import pair_diff_pkg::*;
#(
  parameter int           W      = 20,
  parameter logic [W-1:0] OFFSET = W'(DEF_OFFSET),
  parameter bit           SAT    = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         vld,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         order,
  output logic [W-1:0] out_data,
  output logic         o_dval,
  output logic         o_ovf
);

  // Stage 1: signed (W+1)-bit difference.
  logic [W:0] raw;
  logic [W:0] raw_q;
  logic       vld_q;

  always_comb begin
    raw = order ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      raw_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= vld;
      if (vld) raw_q <= raw;
    end
  end

  // Stage 2: add offset in (W+2) bits, then clip or wrap.
  logic [W+1:0]  s;
  logic [SW-1:0] s_ext;
  logic [W-1:0]  clip;
  logic          ovf;
  logic [W-1:0]  dat_n;

  always_comb begin
    s            = {raw_q[W], raw_q} + {2'b00, OFFSET};
    s_ext        = {{(SW-W-2){s[W+1]}}, s};
    {clip, ovf}  = (W+1)'(sat_clip(s_ext, W));
    dat_n        = SAT ? clip : s[W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data <= '0;
      o_dval   <= 1'b0;
      o_ovf    <= 1'b0;
    end else begin
      o_dval <= vld_q;
      // out_data/o_ovf hold between results.
      if (vld_q) begin
        out_data <= dat_n;
        o_ovf    <= ovf;
      end
    end
  end

endmodule

// File: rtl/pair_diff_ch.sv
// Pairs the dval/mlt stream into (A,B) and emits one offset-corrected difference per pair.
// Latency: B's dval at cycle N -> o_dval at cycle N+2; one pair per 2 cycles sustained.
// Backpressure: none; sync and orphan timeout drop A but never cancel results in flight.
// Ports: clk, rst (async active-low), dval/mlt/sync/order in; out_data/o_dval/o_ovf, pair_cnt/drop_cnt out.
module pair_diff_ch
  import pair_diff_pkg::*;
#(
  parameter int           W       = 20,
  parameter logic [W-1:0] OFFSET  = W'(DEF_OFFSET),
  parameter bit           SAT     = 1'b1,
  parameter int           TIMEOUT = 1024,
  parameter int           CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dval,
  input  logic [W-1:0]     mlt,
  input  logic             sync,
  input  logic             order,
  output logic [W-1:0]     out_data,
  output logic             o_dval,
  output logic             o_ovf,
  output logic [CNT_W-1:0] pair_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  state_t       state, state_n;
  logic [W-1:0] a_q;
  logic         cap_a;
  logic         launch;
  logic         drop;
  logic         tmo_hit;

  // Next-state and event decode. sync wins over everything; a dval on the
  // timeout cycle completes the pair because dval is tested before tmo_hit.
  always_comb begin
    state_n = state;
    cap_a   = 1'b0;
    launch  = 1'b0;
    drop    = 1'b0;
    case (state)
      IDLE: begin
        if (dval) begin
          cap_a   = 1'b1;
          state_n = WAIT_B;
        end
      end
      WAIT_B: begin
        if (sync) begin
          drop = 1'b1;
          if (dval) begin
            cap_a   = 1'b1;
            state_n = WAIT_B;
          end else begin
            state_n = IDLE;
          end
        end else if (dval) begin
          launch  = 1'b1;
          state_n = IDLE;
        end else if (tmo_hit) begin
          drop    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      a_q      <= '0;
      pair_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state_n;
      if (cap_a)  a_q      <= mlt;
      if (launch) pair_cnt <= pair_cnt + CNT_W'(1);
      if (drop)   drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  // Orphan timer: counts idle WAIT_B cycles since A. It reads TIMEOUT-1 on
  // the TIMEOUT-th cycle after A, which is the cycle A gets discarded.
  generate
    if (TIMEOUT > 0) begin : g_tmr
      localparam int TW = $clog2(TIMEOUT + 1);
      logic [TW-1:0] timer;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 timer <= '0;
        else if (cap_a)           timer <= '0;
        else if (state == WAIT_B) timer <= timer + TW'(1);
      end

      assign tmo_hit = (timer == TW'(TIMEOUT - 1));
    end else begin : g_no_tmr
      assign tmo_hit = 1'b0;
    end
  endgenerate

  pair_diff_arith #(
    .W      (W),
    .OFFSET (OFFSET),
    .SAT    (SAT)
  ) u_arith (
    .clk      (clk),
    .rst      (rst),
    .vld      (launch),
    .a        (a_q),
    .b        (mlt),
    .order    (order),
    .out_data (out_data),
    .o_dval   (o_dval),
    .o_ovf    (o_ovf)
  );

endmodule

// File: tb/tb_pair_diff_ch.sv
// Randomised plus directed bench for pair_diff_ch.
// Two instances share stimulus: [0] saturating with TIMEOUT=16, [1] wrapping with no timeout.
// A pair-level reference model predicts every output each cycle.
module tb_pair_diff_ch;

  localparam int     W    = 20;
  localparam int     CW   = 8;
  localparam longint OFS  = 'h7F0;
  localparam longint MAXV = (64'd1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          dval = 1'b0;
  logic          sync = 1'b0;
  logic          order = 1'b0;
  logic [W-1:0]  mlt = '0;

  logic [W-1:0]  od [2];
  logic          ov [2];
  logic          odv [2];
  logic [CW-1:0] pc [2];
  logic [CW-1:0] dc [2];

  always #5 clk = ~clk;

  pair_diff_ch #(.W(W), .OFFSET(20'h007F0), .SAT(1'b1), .TIMEOUT(16), .CNT_W(CW)) dut_sat (
    .clk(clk), .rst(rst), .dval(dval), .mlt(mlt), .sync(sync), .order(order),
    .out_data(od[0]), .o_dval(odv[0]), .o_ovf(ov[0]), .pair_cnt(pc[0]), .drop_cnt(dc[0])
  );

  pair_diff_ch #(.W(W), .OFFSET(20'h007F0), .SAT(1'b0), .TIMEOUT(0), .CNT_W(CW)) dut_wrap (
    .clk(clk), .rst(rst), .dval(dval), .mlt(mlt), .sync(sync), .order(order),
    .out_data(od[1]), .o_dval(odv[1]), .o_ovf(ov[1]), .pair_cnt(pc[1]), .drop_cnt(dc[1])
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit     m_has [2];
  longint m_a   [2];
  int     m_age [2];
  bit     p_vld [2];
  longint p_a   [2];
  longint p_b   [2];
  bit     p_ord [2];
  bit     e_vld [2];
  longint e_dat [2];
  bit     e_ovf [2];
  int     e_pair[2];
  int     e_drop[2];

  function automatic bit sat_of(input int k);
    return (k == 0);
  endfunction

  function automatic int tmo_of(input int k);
    return (k == 0) ? 16 : 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_has[k] = 0; m_a[k] = 0; m_age[k] = 0;
      p_vld[k] = 0; p_a[k] = 0; p_b[k] = 0; p_ord[k] = 0;
      e_vld[k] = 0; e_dat[k] = 0; e_ovf[k] = 0;
      e_pair[k] = 0; e_drop[k] = 0;
    end
  endtask

  task automatic model_edge(input bit d, input longint m, input bit s, input bit o);
    longint t;
    for (int k = 0; k < 2; k++) begin
      // result of a pair launched on the previous edge becomes visible now
      e_vld[k] = p_vld[k];
      if (p_vld[k]) begin
        t = p_ord[k] ? (p_a[k] - p_b[k]) : (p_b[k] - p_a[k]);
        t = t + OFS;
        e_ovf[k] = (t < 0) || (t > MAXV);
        if (sat_of(k)) e_dat[k] = (t < 0) ? 0 : ((t > MAXV) ? MAXV : t);
        else           e_dat[k] = t & MAXV;
      end
      p_vld[k] = 0;
      if (s) begin
        if (m_has[k]) e_drop[k] = (e_drop[k] + 1) % 256;
        m_has[k] = d; m_a[k] = m; m_age[k] = 0;
      end else if (d && m_has[k]) begin
        p_vld[k] = 1; p_a[k] = m_a[k]; p_b[k] = m; p_ord[k] = o;
        e_pair[k] = (e_pair[k] + 1) % 256;
        m_has[k] = 0;
      end else if (d) begin
        m_has[k] = 1; m_a[k] = m; m_age[k] = 0;
      end else if (m_has[k]) begin
        m_age[k]++;
        if (tmo_of(k) > 0 && m_age[k] == tmo_of(k)) begin
          m_has[k] = 0;
          e_drop[k] = (e_drop[k] + 1) % 256;
        end
      end
    end
  endtask

  task automatic check_all(input string ctx);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s.o_dval[%0d]", ctx, k), 32'(odv[k]), 32'(e_vld[k]));
      chk($sformatf("%s.out_data[%0d]", ctx, k), 32'(od[k]), 32'(e_dat[k]));
      if (e_vld[k]) chk($sformatf("%s.o_ovf[%0d]", ctx, k), 32'(ov[k]), 32'(e_ovf[k]));
      chk($sformatf("%s.pair_cnt[%0d]", ctx, k), 32'(pc[k]), 32'(e_pair[k]));
      chk($sformatf("%s.drop_cnt[%0d]", ctx, k), 32'(dc[k]), 32'(e_drop[k]));
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit d, input logic [W-1:0] m, input bit s, input bit o, input string ctx);
    dval = d; mlt = m; sync = s; order = o;
    @(posedge clk);
    model_edge(d, longint'(m), s, o);
    #1;
    check_all(ctx);
  endtask

  task automatic idle(input int n, input string ctx);
    for (int i = 0; i < n; i++) step(1'b0, W'($urandom), 1'b0, 1'($urandom), ctx);
  endtask

  task automatic do_reset(input string ctx);
    @(negedge clk);
    dval = 1'b0; sync = 1'b0;
    rst = 1'b0;
    #1;
    model_reset();
    check_all(ctx);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic pair(input logic [W-1:0] a, input logic [W-1:0] b, input bit o, input string ctx);
    step(1'b1, a, 1'b0, 1'b0, ctx);
    step(1'b1, b, 1'b0, o, ctx);
    idle(2, ctx);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset.out_data", 32'(od[k]), 32'h0);
      chk("reset.o_dval", 32'(odv[k]), 32'h0);
      chk("reset.pair_cnt", 32'(pc[k]), 32'h0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // basic pair and order swap
    pair(20'h00100, 20'h00300, 1'b0, "basic");
    chk("basic.value", 32'(od[0]), 32'h009F0);
    chk("basic.pair_cnt", 32'(pc[0]), 32'h1);
    pair(20'h00100, 20'h00300, 1'b1, "swap");
    chk("swap.value", 32'(od[0]), 32'h005F0);

    // overflow in both directions, clamped and wrapped
    pair(20'h00000, 20'hFFFFF, 1'b0, "ovf_hi");
    chk("ovf_hi.sat", 32'(od[0]), 32'hFFFFF);
    chk("ovf_hi.wrap", 32'(od[1]), 32'h007EF);
    chk("ovf_hi.flag", 32'(ov[1]), 32'h1);
    pair(20'h01000, 20'h00000, 1'b0, "ovf_lo");
    chk("ovf_lo.sat", 32'(od[0]), 32'h00000);
    chk("ovf_lo.wrap", 32'(od[1]), 32'hFF7F0);
    chk("ovf_lo.flag", 32'(ov[0]), 32'h1);

    // orphan timeout: late sample at N+17 is a new A, at N+16 it is B
    do_reset("tmo_rst");
    step(1'b1, 20'h00040, 1'b0, 1'b0, "tmo");
    idle(16, "tmo");
    step(1'b1, 20'h00050, 1'b0, 1'b0, "tmo");
    chk("tmo.drop", 32'(dc[0]), 32'h1);
    step(1'b1, 20'h00060, 1'b0, 1'b0, "tmo");
    idle(2, "tmo");
    chk("tmo.pair", 32'(pc[0]), 32'h1);
    step(1'b1, 20'h00040, 1'b0, 1'b0, "tmo_edge");
    idle(15, "tmo_edge");
    step(1'b1, 20'h00050, 1'b0, 1'b0, "tmo_edge");
    idle(2, "tmo_edge");
    chk("tmo_edge.drop", 32'(dc[0]), 32'h1);
    chk("tmo_edge.pair", 32'(pc[0]), 32'h2);

    // sync realign
    do_reset("sync_rst");
    step(1'b1, 20'd5, 1'b0, 1'b0, "sync");
    step(1'b1, 20'd10, 1'b1, 1'b0, "sync");
    step(1'b1, 20'd30, 1'b0, 1'b0, "sync");
    idle(2, "sync");
    chk("sync.value", 32'(od[0]), 32'h00804);
    chk("sync.drop", 32'(dc[0]), 32'h1);
    chk("sync.pair", 32'(pc[0]), 32'h1);

    // back-to-back samples, then long enough to wrap pair_cnt
    for (int i = 0; i < 8; i++) step(1'b1, W'($urandom), 1'b0, 1'($urandom), "burst8");
    idle(3, "burst8");
    for (int i = 0; i < 530; i++) step(1'b1, W'($urandom), 1'b0, 1'($urandom), "wrap");
    idle(3, "wrap");

    // reset between A and B
    step(1'b1, 20'h00123, 1'b0, 1'b0, "midrst");
    do_reset("midrst");
    idle(3, "midrst");
    step(1'b1, 20'h00456, 1'b0, 1'b0, "midrst");
    idle(3, "midrst");
    pair(20'h00200, 20'h00100, 1'b0, "after_rst");

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [W-1:0] v;
      r = int'($urandom_range(0, 999));
      case ($urandom_range(0, 3))
        0:       v = 20'h00000;
        1:       v = 20'hFFFFF;
        default: v = W'($urandom);
      endcase
      if (r < 3)       do_reset("rand_rst");
      else if (r < 20) idle(int'($urandom_range(14, 18)), "rand_gap");
      else             step(1'($urandom_range(0, 9) < 6), v, 1'($urandom_range(0, 99) < 4),
                            1'($urandom), "rand");
    end
    idle(3, "drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pair_diff_ch.md
Name: pair_diff_ch

Overview:
- Parametrised successor of the two-sample difference stage in the TDC path.
- Groups the incoming `dval`/`mlt` stream into ordered pairs (first = A, second = B) and emits one offset-corrected difference per pair.
- Adds over the previous generation:
  - generic sample width and offset;
  - runtime subtraction order;
  - optional saturation with an overflow flag;
  - pair-phase resync and an orphan timeout;
  - pair and drop counters for the host register map.
- Sits between the measurement (multiplier) stage and the output FIFO/serialiser.

Parameters:
- W, 20, sample and result width in bits.
- OFFSET, 'h007F0, W-bit unsigned constant added to every difference.
- SAT, 1, 1 = clamp result to [0, 2^W-1]; 0 = wrap modulo 2^W.
- TIMEOUT, 1024, idle cycles after A before A is discarded. 0 disables the timeout.
- CNT_W, 8, width of `pair_cnt` and `drop_cnt`.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous active-low reset. Asserts immediately; release is synchronised externally.
- dval  in  1  sample strobe, one cycle per sample, may be high every cycle.
- mlt  in  W  unsigned sample, valid when `dval` = 1.
- sync  in  1  single-cycle pair-phase realign.
- order  in  1  0: result = B−A+OFFSET; 1: result = A−B+OFFSET. Sampled on B's `dval` cycle.
- out_data  out  W  result, valid when `o_dval` = 1, holds its value otherwise.
- o_dval  out  1  single-cycle result strobe.
- o_ovf  out  1  qualifies `out_data` when `o_dval` = 1: true result was outside [0, 2^W-1].
- pair_cnt  out  CNT_W  completed pairs, wraps.
- drop_cnt  out  CNT_W  discarded A samples, wraps.

Behaviour:
- Reset (`rst` = 0):
  - `out_data`, `o_dval`, `o_ovf`, `pair_cnt` and `drop_cnt` all go to 0.
  - State goes to IDLE; pipeline valids are cleared; timer goes to 0.
  - Reset mid-pair discards A and any results in flight, and does not count a drop.
- State machine, two states:
  - IDLE:
    - `dval` captures A, clears the timer and moves to WAIT_B.
  - WAIT_B:
    - `dval` captures B, launches a result, increments `pair_cnt` and returns to IDLE.
    - Otherwise the timer increments.
    - If A arrived at cycle N and there is no `dval` through cycle N+TIMEOUT, then at the end of cycle N+TIMEOUT: return to IDLE and increment `drop_cnt`.
- Priority within one cycle:
  - `sync` overrides everything.
  - In WAIT_B, `sync` discards A (`drop_cnt`+1).
  - If `dval` is high in the same cycle as `sync`, that sample becomes the new A (state WAIT_B); otherwise the state goes to IDLE.
  - `sync` in IDLE without `dval` has no effect.
  - `dval` on the timeout cycle completes the pair; no drop is counted.
- Arithmetic pipeline, fixed latency:
  - B's `dval` at cycle N gives `o_dval`/`out_data`/`o_ovf` registered at cycle N+2.
  - Stage 1: raw = signed (W+1)-bit B−A, or A−B when `order` = 1.
  - Stage 2: s = raw + OFFSET in signed (W+2)-bit; `o_ovf` = (s < 0) or (s > 2^W−1).
  - If SAT = 1: output is clamped to 0 or 2^W−1.
  - If SAT = 0: output is s[W−1:0].
- Throughput:
  - One pair every 2 cycles when `dval` is high continuously; no bubbles, no backpressure.
  - `sync`/timeout never cancels results already in the pipeline.
- Counters:
  - `pair_cnt` updates on B's capture cycle; `drop_cnt` updates on the drop cycle.
  - Both wrap from 2^CNT_W−1 to 0.
- Constraint: TIMEOUT must fit a clog2(TIMEOUT+1)-bit timer; TIMEOUT = 0 removes the timer logic.

Decomposition:
- Package `pair_diff_pkg`:
  - state enum {IDLE, WAIT_B};
  - function `sat_clip(s, W)` returning the clipped value and the overflow bit;
  - default OFFSET localparam.
- One sub-module, `pair_diff_arith`:
  - the 2-stage subtract/offset/saturate pipeline, parametrised by W, OFFSET and SAT;
  - instantiated by `pair_diff_ch`, which owns the FSM, timer and counters.

Test Plan:
- All cases W=20, OFFSET='h7F0.
- Basic pair: A='h00100 then B='h00300, `order`=0 → `o_dval` exactly 2 cycles after B; `out_data`='h009F0, `o_ovf`=0, `pair_cnt`=1.
- Order swap: same samples, `order`=1 → `out_data`='h005F0.
- Overflow, SAT=1:
  - A=0, B='hFFFFF → 'hFFFFF, `o_ovf`=1.
  - A='h01000, B=0 → 0, `o_ovf`=1.
  - Same stimulus with SAT=0 → 'h007EF and 'hFF7F0, `o_ovf`=1 both times.
- Timeout, TIMEOUT=16:
  - A at cycle N, next `dval` at N+17 → `drop_cnt`=1, that sample becomes the new A; the following `dval` completes the pair.
  - Repeat with B at N+16 → pair completes, `drop_cnt` unchanged.
- Sync realign: A=5, then `sync`+`dval`(X=10), then `dval`(B=30) → one result 'h00804, `drop_cnt`=1, `pair_cnt`=1.
- Stress and reset:
  - 8 consecutive `dval` → 4 `o_dval` pulses spaced 2 cycles apart with correct values; `pair_cnt` wraps after 256 pairs (CNT_W=8).
  - `rst` pulse between A and B → all outputs 0 and no `o_dval` until two new samples arrive.
